// File: rtl/packet_serializer.sv
// Packet serializer: requests the head packet of the selected core's queue, captures it on
// the valid pulse and streams it out as BEAT_WIDTH-bit beats. Optional: SERIALIZER_TIMEOUT_EN.
module packet_serializer #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  parameter int DATA_SIZE        = 678,
  parameter int BEAT_WIDTH       = 128
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                pending,
  input  logic [$clog2(NUMBER_OF_QUEUES)-1:0] core_id,
  output logic                                serializer_to_queues_ready,
  input  logic                                queues_to_serializer_valid,
  input  logic [DATA_SIZE-1:0]                queues_to_serializer_packet,
  output logic [BEAT_WIDTH-1:0]               m_data,
  output logic                                m_valid,
  output logic                                m_last,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0] m_core_id,
  input  logic                                m_ready,
  output logic [REGISTER_SIZE-1:0]            packets_sent,
  input  logic [REGISTER_SIZE-1:0]            timeout_cycles,
  output logic                                timeout_error
);
  localparam int CIDW  = $clog2(NUMBER_OF_QUEUES);
  localparam int BEATS = (DATA_SIZE + BEAT_WIDTH - 1) / BEAT_WIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_SEND} state_t;

  state_t                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic [DATA_SIZE-1:0]     capture_q, capture_d;
  logic [BCW-1:0]           beat_q, beat_d;
  logic                     m_valid_q, m_valid_d;
  logic [CIDW-1:0]          m_core_id_q, m_core_id_d;
  logic [REGISTER_SIZE-1:0] sent_q, sent_d;
`ifdef SERIALIZER_TIMEOUT_EN
  logic [REGISTER_SIZE-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                     tmo_err_q, tmo_err_d;
`endif

  // Zero-padded view so the final beat carries the remainder with zero upper bits.
  logic [BEATS*BEAT_WIDTH-1:0]         padded;
  logic [BEATS-1:0][BEAT_WIDTH-1:0]    beats_w;

  always_comb begin
    padded                 = '0;
    padded[DATA_SIZE-1:0]  = capture_q;
  end
  assign beats_w = padded;

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    capture_d   = capture_q;
    beat_d      = beat_q;
    m_valid_d   = m_valid_q;
    m_core_id_d = m_core_id_q;
    sent_d      = sent_q;
`ifdef SERIALIZER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_err_d   = tmo_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pending) begin
          state_d     = S_REQUEST;
          ready_d     = 1'b1;
          m_core_id_d = core_id;
`ifdef SERIALIZER_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end
      S_REQUEST: begin
        if (queues_to_serializer_valid) begin
          capture_d = queues_to_serializer_packet;
          ready_d   = 1'b0;
          beat_d    = '0;
          m_valid_d = 1'b1;
          state_d   = S_SEND;
        end
`ifdef SERIALIZER_TIMEOUT_EN
        // Expire after exactly timeout_cycles REQUEST cycles without a pulse.
        else if (timeout_cycles != '0 && (tmo_cnt_q + 1'b1) == timeout_cycles) begin
          ready_d   = 1'b0;
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      S_SEND: begin
        if (m_valid_q && m_ready) begin
          if (beat_q == LAST_BEAT) begin
            m_valid_d = 1'b0;
            sent_d    = sent_q + 1'b1;
            state_d   = S_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      capture_q   <= '0;
      beat_q      <= '0;
      m_valid_q   <= 1'b0;
      m_core_id_q <= '0;
      sent_q      <= '0;
`ifdef SERIALIZER_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      capture_q   <= capture_d;
      beat_q      <= beat_d;
      m_valid_q   <= m_valid_d;
      m_core_id_q <= m_core_id_d;
      sent_q      <= sent_d;
`ifdef SERIALIZER_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_err_q   <= tmo_err_d;
`endif
    end
  end

  assign serializer_to_queues_ready = ready_q;
  assign m_valid      = m_valid_q;
  assign m_data       = beats_w[beat_q];
  assign m_last       = m_valid_q && (beat_q == LAST_BEAT);
  assign m_core_id    = m_core_id_q;
  assign packets_sent = sent_q;

`ifdef SERIALIZER_TIMEOUT_EN
  assign timeout_error = tmo_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign timeout_error  = 1'b0;
`endif

endmodule

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
Reader end of the per-core queueing domain. When a queued packet is pending, it requests the head packet for the scheduler-selected core with a level ready and captures the wide packet on the returning 1-cycle valid pulse. It then emits the packet as BEAT_WIDTH-bit beats on a valid/ready stream toward the memory-side port. It sits between the queueing domain output and the downstream interconnect master.

Parameters:
NUMBER_OF_QUEUES, 4, number of per-core queues; sets core_id width
REGISTER_SIZE, 32, width of the packet counter and timeout register
DATA_SIZE, 678, packet width in bits
BEAT_WIDTH, 128, output beat width; BEATS = ceil(DATA_SIZE/BEAT_WIDTH) (6 at defaults)

Ports:
clock  in  1  single clock, all logic posedge
reset  in  1  asynchronous, active-low reset (active when 0)
pending  in  1  selected core's queue non-empty (~empty[core_id])
core_id  in  $clog2(NUMBER_OF_QUEUES)  scheduler-selected core
serializer_to_queues_ready  out  1  request head packet; queueing domain detects its rising edge
queues_to_serializer_valid  in  1  1-cycle pulse; packet valid this cycle
queues_to_serializer_packet  in  DATA_SIZE  head packet
m_data  out  BEAT_WIDTH  current beat
m_valid  out  1  beat valid
m_last  out  1  final beat of packet
m_core_id  out  $clog2(NUMBER_OF_QUEUES)  core_id latched at request
m_ready  in  1  downstream accepts beat
packets_sent  out  REGISTER_SIZE  completed-packet count, wraps modulo 2^REGISTER_SIZE
timeout_cycles  in  REGISTER_SIZE  request timeout limit (used only with the optional feature)
timeout_error  out  1  sticky timeout flag (constant 0 without the optional feature)

Behaviour:
- Reset (reset=0, async): state IDLE; serializer_to_queues_ready=0, m_valid=0, m_last=0, m_data=0, m_core_id=0, packets_sent=0, timeout_error=0; beat counter=0; capture register=0. Reset mid-frame drops the frame immediately; no partial-frame resume.
- FSM states IDLE, REQUEST, SEND.
- IDLE: if pending=1, go to REQUEST next cycle and latch core_id into m_core_id. Ready is registered and asserts in the REQUEST cycle.
- REQUEST: ready=1. On queues_to_serializer_valid=1, capture the packet that cycle, deassert ready next cycle, go to SEND, beat counter=0.
- queues_to_serializer_valid outside REQUEST is ignored; no capture.
- SEND: m_valid=1 starting the cycle after capture. m_data = capture[k*BEAT_WIDTH +: BEAT_WIDTH] for beat k. The final beat carries the high-order remainder in its LSBs; unused upper bits are 0.
- Advance the beat only on m_valid & m_ready.
- m_data, m_last and m_core_id are stable while m_valid & ~m_ready (no drop, no change).
- m_last=1 only on beat BEATS-1.
- Handshake on the last beat: m_valid=0 next cycle, packets_sent+1 (wraps), go to IDLE.
- Ready is low for at least one full cycle between requests, guaranteeing a fresh rising edge. With pending held high, the next ready asserts 2 cycles after the last handshake.
- core_id changes outside IDLE have no effect.
- BEATS=1 (DATA_SIZE<=BEAT_WIDTH): single beat with m_last=1.
- Best-case latency: valid pulse at cycle N gives beat 0 valid at N+1; a packet occupies BEATS cycles under m_ready=1.

Optional Feature:
SERIALIZER_TIMEOUT_EN
- Defined: a counter runs in REQUEST. If timeout_cycles!=0 and the counter reaches timeout_cycles with no valid pulse, ready drops, the FSM returns to IDLE, and timeout_error sets (sticky until reset). The counter clears on entering REQUEST. timeout_cycles=0 disables the timeout.
- Undefined: REQUEST waits indefinitely; timeout_error tied to 0; timeout_cycles unused.

Test Plan:
- Single packet, defaults, m_ready=1, packet bit i = i[0] pattern, core_id=2 -> ready 1 cycle; 6 consecutive beats; beat 5 holds bits [677:640] in m_data[37:0], [127:38]=0; m_last only on beat 5; m_core_id=2; packets_sent=1.
- Backpressure: m_ready toggles 1,0,0,1 per cycle -> no beat lost or duplicated; m_data stable across stalls; 6 handshakes total.
- Back-to-back: pending held 1 for 3 packets -> ready low ≥1 cycle between requests; 3 distinct rising edges; packets_sent=3.
- Stray valid pulse in IDLE and SEND -> no capture; output beats unchanged.
- Reset asserted at beat 3 -> m_valid=0 asynchronously; after release, state IDLE; packets_sent=0.
- With SERIALIZER_TIMEOUT_EN, timeout_cycles=5, no valid -> ready drops after 5 cycles; timeout_error=1 and stays 1; next pending re-requests normally.
